// File: rtl/shift_issue_stage_if.sv
// Purpose : bundles the command, shifter and result signals of shift_issue_stage.
// Ports   : in_* command handshake, sh_* combinational shifter drive/return,
//           out_* result handshake, occupancy of the command FIFO.
// Modports: slave = the issue stage; master = its environment (upstream, shifter, downstream).
interface shift_issue_stage_if #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) ();
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [5:0]       in_amount;
  logic             in_dir;
  logic             in_type;
  logic [TAG_W-1:0] in_tag;

  logic [31:0]      sh_data;
  logic [4:0]       sh_amount;
  logic             sh_dir;
  logic             sh_type;
  logic [31:0]      sh_result;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_sat;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  in_valid, in_data, in_amount, in_dir, in_type, in_tag,
    output in_ready,
    output sh_data, sh_amount, sh_dir, sh_type,
    input  sh_result,
    output out_valid, out_data, out_tag, out_sat,
    input  out_ready,
    output occupancy
  );

  modport master (
    output in_valid, in_data, in_amount, in_dir, in_type, in_tag,
    input  in_ready,
    input  sh_data, sh_amount, sh_dir, sh_type,
    output sh_result,
    input  out_valid, out_data, out_tag, out_sat,
    output out_ready,
    input  occupancy
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Purpose : buffers shift commands in a DEPTH-entry FIFO, drives the external
//           32-bit shifter from the FIFO head and registers its result.
// Latency : accept at edge N -> out_valid at edge N+1 at the earliest; 1 result/cycle sustained.
// Backpressure: in_ready = FIFO not full (registered state only); the head issues
//           whenever the output register is empty or being drained this cycle.
// Ports   : clk, rst_n (async active-low); bus = shift_issue_stage_if.slave
//           (in_* command, sh_* shifter drive/return, out_* result, occupancy).
module shift_issue_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  shift_issue_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      data;
    logic [5:0]       amount;
    logic             dir;
    logic             typ;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_sat;

  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  cmd_t             w_head;
  logic             w_sat;
  logic [31:0]      w_result;

  assign w_not_empty  = (r_count != '0);
  assign bus.in_ready = (r_count < OCC_W'(DEPTH));
  assign w_push       = bus.in_valid & bus.in_ready;
  assign w_pop        = w_not_empty & (~r_out_valid | bus.out_ready);
  assign w_head       = r_mem[r_rd_ptr];

  // Shifter inputs are forced to zero when idle so it sees a quiet operand.
  assign bus.sh_data   = w_not_empty ? w_head.data        : '0;
  assign bus.sh_amount = w_not_empty ? w_head.amount[4:0] : '0;
  assign bus.sh_dir    = w_not_empty ? w_head.dir         : 1'b0;
  assign bus.sh_type   = w_not_empty ? w_head.typ         : 1'b0;

  // Amounts 32..63 shift every operand bit out, so the result is just the
  // fill value: sign bits for arithmetic right, zero otherwise.
  assign w_sat    = w_head.amount[5];
  assign w_result = !w_sat ? bus.sh_result :
                    (w_head.dir & w_head.typ) ? {32{w_head.data[31]}} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{data:   bus.in_data,
                             amount: bus.in_amount,
                             dir:    bus.in_dir,
                             typ:    bus.in_type,
                             tag:    bus.in_tag};
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_tag   <= w_head.tag;
      r_out_sat   <= w_sat;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_sat   = r_out_sat;
  assign bus.occupancy = r_count;
endmodule

// File: tb/tb_shift_issue_stage.sv
// Purpose : randomized + directed bench for shift_issue_stage with a scoreboard.
// Latency : n/a (bench).
// Backpressure: bench toggles out_ready and in_valid to exercise stalls.
module tb_shift_issue_stage;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_issue_stage_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  shift_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Stand-in for the combinational shifter downstream of the stage.
  assign bus.sh_result = !bus.sh_dir ? (bus.sh_data << bus.sh_amount) :
                         bus.sh_type ? 32'($signed(bus.sh_data) >>> bus.sh_amount) :
                                       (bus.sh_data >> bus.sh_amount);

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  int   max_occ = 0;
  int   m_cnt = 0;
  bit   m_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Behavioural reference: full 6-bit amount applied with plain shifts on a
  // wide value; shifting past the width naturally yields the fill value.
  function automatic exp_t ref_model(input logic [31:0] d, input logic [5:0] a,
                                     input logic dr, input logic ty,
                                     input logic [TAG_W-1:0] t);
    exp_t e;
    logic [63:0] wide;
    e.tag = t;
    e.sat = (a >= 6'd32);
    if (!dr) begin
      wide   = {32'h0, d} << a;
      e.data = wide[31:0];
    end else if (ty) begin
      e.data = 32'($signed(d) >>> a);
    end else begin
      e.data = d >> a;
    end
    return e;
  endfunction

  // Monitor + cycle model of occupancy/out_valid; pushes expectations on accept.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   push;
    bit   pop;
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_occupancy", bus.occupancy, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      chk("rst_out_sat", bus.out_sat, 0);
      sb.delete();
      m_cnt = 0;
      m_ov  = 1'b0;
    end else begin
      chk("occupancy", bus.occupancy, m_cnt);
      chk("in_ready", bus.in_ready, (m_cnt < DEPTH));
      chk("out_valid", bus.out_valid, m_ov);
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          fail_now("sb_unexpected_output");
        end else begin
          e = sb.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_tag", bus.out_tag, e.tag);
          chk("sb_sat", bus.out_sat, e.sat);
        end
      end
      push = bus.in_valid && (m_cnt < DEPTH);
      pop  = (m_cnt != 0) && (!m_ov || bus.out_ready);
      if (push) sb.push_back(ref_model(bus.in_data, bus.in_amount, bus.in_dir,
                                       bus.in_type, bus.in_tag));
      if (pop) m_ov = 1'b1;
      else if (bus.out_ready) m_ov = 1'b0;
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [5:0] a, input logic dr,
                      input logic ty, input logic [TAG_W-1:0] t);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = a;
    bus.in_dir    = dr;
    bus.in_type   = ty;
    bus.in_tag    = t;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    fail_now("send_accept");
  endtask

  task automatic expect_out(input string name, input logic [31:0] d,
                            input logic [TAG_W-1:0] t, input logic s);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        chk({name, "_data"}, bus.out_data, d);
        chk({name, "_tag"}, bus.out_tag, t);
        chk({name, "_sat"}, bus.out_sat, s);
        return;
      end
    end
    fail_now({name, "_wait"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_dir    = 1'b0;
    bus.in_type   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic left shift with one-cycle issue latency.
    send(32'h0000_00F0, 6'd4, 1'b0, 1'b0, 4'd3);
    @(negedge clk);
    chk("t2_lat_early", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_data", bus.out_data, 32'h0000_0F00);
    chk("t2_tag", bus.out_tag, 3);
    chk("t2_sat", bus.out_sat, 0);
    @(posedge clk); #1;

    // Saturated amounts: arithmetic right fills with sign, logical with zero.
    send(32'h8000_0000, 6'd40, 1'b1, 1'b1, 4'd5);
    expect_out("t3a", 32'hFFFF_FFFF, 4'd5, 1'b1);
    @(posedge clk); #1;
    send(32'h8000_0000, 6'd32, 1'b1, 1'b0, 4'd6);
    expect_out("t3b", 32'h0000_0000, 4'd6, 1'b1);
    @(posedge clk); #1;

    // Zero-amount arithmetic right passes the operand through.
    send(32'h8000_0001, 6'd0, 1'b1, 1'b1, 4'd7);
    expect_out("t6", 32'h8000_0001, 4'd7, 1'b0);
    @(posedge clk); #1;

    // Backpressure: three accepts fill output register + FIFO.
    bus.out_ready = 1'b0;
    send(32'h1, 6'd1, 1'b0, 1'b0, 4'd1);
    send(32'h2, 6'd2, 1'b0, 1'b0, 4'd2);
    send(32'h3, 6'd3, 1'b0, 1'b0, 4'd3);
    @(negedge clk);
    chk("t4_in_ready_full", bus.in_ready, 0);
    chk("t4_occ_full", bus.occupancy, 2);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++)
      expect_out("t4_order", 32'(i) << i, 4'(i), 1'b0);
    @(posedge clk); #1;

    // Mid-stream reset with FIFO full and out_valid set.
    bus.out_ready = 1'b0;
    send(32'hA5A5_0001, 6'd0, 1'b0, 1'b0, 4'd9);
    send(32'hA5A5_0002, 6'd0, 1'b0, 1'b0, 4'd10);
    send(32'hA5A5_0003, 6'd0, 1'b0, 1'b0, 4'd11);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_occupancy", bus.occupancy, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Streaming: 8 commands, one result per cycle, occupancy stays <= 1.
    repeat (2) @(posedge clk);
    #1;
    max_occ = 0;
    n0 = n_out;
    for (int i = 0; i < 8; i++)
      send($urandom, 6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom), 4'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_results", n_out - n0, 8);
    chk("t5_max_occ_le1", (max_occ <= 1), 1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
      bus.in_amount = 6'($urandom_range(0, 63));
      bus.in_dir    = 1'($urandom);
      bus.in_type   = 1'($urandom);
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_occ", bus.occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
